// File: rtl/tdsp_phase_seq.sv
// tdsp_phase_seq: machine-cycle phase generator for the TDSP core.
//
// Produces a registered one-hot phase vector with NUM_PHASES phases per
// machine cycle. At WAIT_PHASE the sequencer can hold off. It does this when
// the bus is requested but not yet granted, or when a programmable wait count
// is non-zero. A recovery interval follows before the held phase is issued.
// bio and the interrupt lines are synchronised through SYNC_STAGES flops.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low reset
//   bus_request  core requests the external bus this machine cycle
//   bus_grant    arbiter grant
//   wait_states  extra wait cycles, sampled only at the WAIT_PHASE decision
//   bio          asynchronous branch-on-IO input
//   int_i        asynchronous interrupt inputs (the name "int" is reserved)
//   phi          registered one-hot phase, phi[k] = phase k+1
//   samp_bio     synchronised bio
//   samp_int     synchronised interrupts
//   stalled      high in every cycle where phi is zero due to wait/recovery
//   cycle_done   high exactly when the last phase is high
module tdsp_phase_seq #(
  parameter int NUM_PHASES      = 6,
  parameter int WAIT_PHASE      = 3,
  parameter int RECOVERY_CYCLES = 1,
  parameter int WS_W            = 4,
  parameter int NUM_IRQ         = 1,
  parameter int SYNC_STAGES     = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bus_request,
  input  logic                  bus_grant,
  input  logic [WS_W-1:0]       wait_states,
  input  logic                  bio,
  input  logic [NUM_IRQ-1:0]    int_i,
  output logic [NUM_PHASES-1:0] phi,
  output logic                  samp_bio,
  output logic [NUM_IRQ-1:0]    samp_int,
  output logic                  stalled,
  output logic                  cycle_done
);

  localparam int IDX_W = $clog2(NUM_PHASES);
  localparam int REC_W = 4;

  localparam logic [1:0] ST_PHASE = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_REC   = 2'd2;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_PHASES - 1);
  localparam logic [IDX_W-1:0] WP_IDX   = IDX_W'(WAIT_PHASE - 1);
  // Index that follows the re-issued wait phase, wrapping at the cycle end.
  localparam logic [IDX_W-1:0] WP_NEXT  =
    (WAIT_PHASE == NUM_PHASES) ? '0 : IDX_W'(WAIT_PHASE);
  localparam logic [REC_W-1:0] REC_INIT = REC_W'(RECOVERY_CYCLES - 1);

  function automatic logic [NUM_PHASES-1:0] onehot(input logic [IDX_W-1:0] i);
    onehot = NUM_PHASES'(1) << i;
  endfunction

  logic [1:0]            state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [WS_W-1:0]       ws_cnt_q, ws_cnt_d;
  logic [REC_W-1:0]      rec_cnt_q, rec_cnt_d;
  logic [NUM_PHASES-1:0] phi_q, phi_d;
  logic                  stalled_q, stalled_d;
  logic                  cycle_done_q, cycle_done_d;
  logic                  stall_req;

  logic [SYNC_STAGES-1:0]              bio_sync_q;
  logic [SYNC_STAGES-1:0][NUM_IRQ-1:0] int_sync_q;

  assign stall_req = (bus_request && !bus_grant) || (wait_states != '0);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    ws_cnt_d  = ws_cnt_q;
    rec_cnt_d = rec_cnt_q;
    phi_d     = '0;
    stalled_d = 1'b0;
    case (state_q)
      ST_PHASE: begin
        if (idx_q > LAST_IDX) begin
          // Unreachable index: emit no phase and restart the cycle.
          idx_d = '0;
        end else if (idx_q == WP_IDX && stall_req) begin
          stalled_d = 1'b1;
          ws_cnt_d  = wait_states;
          state_d   = ST_WAIT;
        end else begin
          phi_d = onehot(idx_q);
          idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + IDX_W'(1);
        end
      end
      ST_WAIT: begin
        stalled_d = 1'b1;
        if (ws_cnt_q != '0) begin
          ws_cnt_d = ws_cnt_q - WS_W'(1);
        end else if (!bus_request || bus_grant) begin
          // A withdrawn request also ends the stall so the core cannot deadlock.
          rec_cnt_d = REC_INIT;
          state_d   = ST_REC;
        end
      end
      ST_REC: begin
        if (rec_cnt_q != '0) begin
          rec_cnt_d = rec_cnt_q - REC_W'(1);
          stalled_d = 1'b1;
        end else begin
          phi_d   = onehot(WP_IDX);
          idx_d   = WP_NEXT;
          state_d = ST_PHASE;
        end
      end
      default: begin
        state_d = ST_PHASE;
        idx_d   = '0;
      end
    endcase
    cycle_done_d = phi_d[NUM_PHASES-1];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_PHASE;
      idx_q        <= '0;
      ws_cnt_q     <= '0;
      rec_cnt_q    <= '0;
      phi_q        <= '0;
      stalled_q    <= 1'b0;
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      ws_cnt_q     <= ws_cnt_d;
      rec_cnt_q    <= rec_cnt_d;
      phi_q        <= phi_d;
      stalled_q    <= stalled_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  // Synchronisers run every cycle, independent of the phase sequencer.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bio_sync_q <= '0;
      int_sync_q <= '0;
    end else begin
      bio_sync_q[0] <= bio;
      int_sync_q[0] <= int_i;
      for (int s = 1; s < SYNC_STAGES; s++) begin
        bio_sync_q[s] <= bio_sync_q[s-1];
        int_sync_q[s] <= int_sync_q[s-1];
      end
    end
  end

  assign phi        = phi_q;
  assign stalled    = stalled_q;
  assign cycle_done = cycle_done_q;
  assign samp_bio   = bio_sync_q[SYNC_STAGES-1];
  assign samp_int   = int_sync_q[SYNC_STAGES-1];

endmodule

// File: tb/tb_tdsp_phase_seq.sv
// Directed testbench for tdsp_phase_seq.
// dut_a: default parameters. dut_b: RECOVERY_CYCLES=3, driven by the same inputs.
// dut_c: NUM_PHASES=8, WAIT_PHASE=5, SYNC_STAGES=3, driven by its own inputs.
module tb_tdsp_phase_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       req = 1'b0, gnt = 1'b0, bio = 1'b0;
  logic [3:0] ws = 4'd0;
  logic [0:0] irq = 1'b0;
  logic       req_c = 1'b0, gnt_c = 1'b0, bio_c = 1'b0;
  logic [3:0] ws_c = 4'd0;
  logic [0:0] irq_c = 1'b0;

  logic [5:0] phi_a, phi_b;
  logic [7:0] phi_c;
  logic       stl_a, stl_b, stl_c, cd_a, cd_b, cd_c, sb_a, sb_b, sb_c;
  logic [0:0] si_a, si_b, si_c;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  tdsp_phase_seq dut_a (
    .clk(clk), .reset(reset), .bus_request(req), .bus_grant(gnt),
    .wait_states(ws), .bio(bio), .int_i(irq), .phi(phi_a),
    .samp_bio(sb_a), .samp_int(si_a), .stalled(stl_a), .cycle_done(cd_a)
  );

  tdsp_phase_seq #(.RECOVERY_CYCLES(3)) dut_b (
    .clk(clk), .reset(reset), .bus_request(req), .bus_grant(gnt),
    .wait_states(ws), .bio(bio), .int_i(irq), .phi(phi_b),
    .samp_bio(sb_b), .samp_int(si_b), .stalled(stl_b), .cycle_done(cd_b)
  );

  tdsp_phase_seq #(.NUM_PHASES(8), .WAIT_PHASE(5), .SYNC_STAGES(3)) dut_c (
    .clk(clk), .reset(reset), .bus_request(req_c), .bus_grant(gnt_c),
    .wait_states(ws_c), .bio(bio_c), .int_i(irq_c), .phi(phi_c),
    .samp_bio(sb_c), .samp_int(si_c), .stalled(stl_c), .cycle_done(cd_c)
  );

  // Hand-computed phi per edge (index 0 = edge 1).
  logic [7:0] t2a [10] = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h08};
  logic [7:0] t2b [12] = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h08};
  logic [7:0] t3a [10] = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h08, 8'h10, 8'h20};
  logic [7:0] t3b [10] = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h08};
  logic [7:0] t4a [10] = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h04, 8'h08, 8'h10, 8'h20, 8'h01};
  logic [7:0] t4b [10] = '{8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h04, 8'h08, 8'h10};
  logic [7:0] t6c [12] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h00, 8'h00, 8'h00, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    req = 1'b0; gnt = 1'b0; ws = 4'd0; bio = 1'b0; irq = 1'b0;
    req_c = 1'b0; gnt_c = 1'b0; ws_c = 4'd0; bio_c = 1'b0; irq_c = 1'b0;
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] e;
    // Reset state while reset is held from time zero.
    #2;
    chk("rst_phi_a", 32'(phi_a), 32'h0);
    chk("rst_stl_a", 32'(stl_a), 32'h0);
    chk("rst_cd_a", 32'(cd_a), 32'h0);
    chk("rst_phi_c", 32'(phi_c), 32'h0);
    tick();
    tick();
    reset = 1'b1;

    // Test 1: free-running phases, no stalls.
    for (int n = 1; n <= 13; n++) begin
      tick();
      e = 8'h01 << ((n - 1) % 6);
      chk($sformatf("t1_phi_a_e%0d", n), 32'(phi_a), 32'(e));
      chk($sformatf("t1_cd_a_e%0d", n), 32'(cd_a), 32'(((n - 1) % 6) == 5));
      chk($sformatf("t1_stl_a_e%0d", n), 32'(stl_a), 32'h0);
      chk($sformatf("t1_phi_b_e%0d", n), 32'(phi_b), 32'(e));
    end

    // Test 2: ungranted request, grant raised before edge 8.
    apply_reset();
    req = 1'b1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      if (n <= 10) begin
        chk($sformatf("t2_phi_a_e%0d", n), 32'(phi_a), 32'(t2a[n-1]));
        chk($sformatf("t2_stl_a_e%0d", n), 32'(stl_a), 32'(t2a[n-1] == 8'h00));
      end
      chk($sformatf("t2_phi_b_e%0d", n), 32'(phi_b), 32'(t2b[n-1]));
      chk($sformatf("t2_stl_b_e%0d", n), 32'(stl_b), 32'(t2b[n-1] == 8'h00));
      if (n == 7) gnt = 1'b1;
      if (n == 9) req = 1'b0;
    end

    // Test 3: two programmed wait states; changes during WAIT are ignored.
    apply_reset();
    ws = 4'd2;
    for (int n = 1; n <= 10; n++) begin
      tick();
      chk($sformatf("t3_phi_a_e%0d", n), 32'(phi_a), 32'(t3a[n-1]));
      chk($sformatf("t3_stl_a_e%0d", n), 32'(stl_a), 32'(t3a[n-1] == 8'h00));
      chk($sformatf("t3_phi_b_e%0d", n), 32'(phi_b), 32'(t3b[n-1]));
      chk($sformatf("t3_stl_b_e%0d", n), 32'(stl_b), 32'(t3b[n-1] == 8'h00));
      if (n == 3) ws = 4'd5;
      if (n == 5) ws = 4'd0;
    end
    chk("t3_cd_a_e10", 32'(cd_a), 32'h1);

    // Test 4: request withdrawn without grant releases the stall.
    apply_reset();
    req = 1'b1;
    for (int n = 1; n <= 10; n++) begin
      tick();
      chk($sformatf("t4_phi_a_e%0d", n), 32'(phi_a), 32'(t4a[n-1]));
      chk($sformatf("t4_phi_b_e%0d", n), 32'(phi_b), 32'(t4b[n-1]));
      if (n == 4) req = 1'b0;
    end

    // Test 5: asynchronous reset in the middle of WAIT.
    apply_reset();
    req = 1'b1; bio = 1'b1; irq = 1'b1;
    for (int n = 1; n <= 4; n++) tick();
    chk("t5_phi_a_wait", 32'(phi_a), 32'h0);
    chk("t5_stl_a_wait", 32'(stl_a), 32'h1);
    chk("t5_sb_a_wait", 32'(sb_a), 32'h1);
    chk("t5_si_a_wait", 32'(si_a), 32'h1);
    reset = 1'b0;
    #2;
    chk("t5_stl_a_async", 32'(stl_a), 32'h0);
    chk("t5_sb_a_async", 32'(sb_a), 32'h0);
    chk("t5_si_a_async", 32'(si_a), 32'h0);
    chk("t5_phi_a_async", 32'(phi_a), 32'h0);
    req = 1'b0; bio = 1'b0; irq = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    chk("t5_phi_a_e1", 32'(phi_a), 32'h01);
    chk("t5_stl_a_e1", 32'(stl_a), 32'h0);

    // Test 6: 8 phases, wait at phase 5, 3-stage synchroniser.
    apply_reset();
    bio_c = 1'b1;
    ws_c = 4'd1;
    for (int n = 1; n <= 12; n++) begin
      tick();
      chk($sformatf("t6_phi_c_e%0d", n), 32'(phi_c), 32'(t6c[n-1]));
      chk($sformatf("t6_cd_c_e%0d", n), 32'(cd_c), 32'(n == 11));
      chk($sformatf("t6_stl_c_e%0d", n), 32'(stl_c), 32'(n >= 5 && n <= 7));
      chk($sformatf("t6_sb_c_e%0d", n), 32'(sb_c), 32'(n == 3));
      if (n == 1) bio_c = 1'b0;
      if (n == 5) ws_c = 4'd0;
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/tdsp_phase_seq.md
Name: tdsp_phase_seq

Overview:
Parametrised successor to the TDSP machine-cycle phase generator. It produces a one-hot phase vector of NUM_PHASES phases per machine cycle. At a configurable phase it inserts wait states, driven by bus arbitration and/or a programmable wait count, followed by a configurable recovery interval. It also synchronises the bio and interrupt inputs through a configurable number of flop stages. It sits beside the TDSP core and drives all phase-qualified datapath and bus timing.

Parameters:
NUM_PHASES, 6, phases per machine cycle; legal 3..16.
WAIT_PHASE, 3, 1-based phase at which stalls are evaluated; legal 1..NUM_PHASES.
RECOVERY_CYCLES, 1, phase-idle cycles between wait exit and the re-issued WAIT_PHASE; legal 1..15.
WS_W, 4, width of the programmable wait-state count.
NUM_IRQ, 1, number of interrupt lines.
SYNC_STAGES, 2, synchroniser depth for bio/int; legal >=1.

Ports:
clk  in  1  system clock; all flops on rising edge.
reset  in  1  asynchronous, active-low reset.
bus_request  in  1  core requests the external bus this machine cycle.
bus_grant  in  1  arbiter grant.
wait_states  in  WS_W  extra wait cycles; sampled only at the WAIT_PHASE decision edge.
bio  in  1  asynchronous branch-on-IO input.
int  in  NUM_IRQ  asynchronous interrupt inputs.
phi  out  NUM_PHASES  registered one-hot phase; phi[k] = phase k+1.
samp_bio  out  1  synchronised bio.
samp_int  out  NUM_IRQ  synchronised int.
stalled  out  1  registered; 1 in every cycle where phi is zero due to wait/recovery.
cycle_done  out  1  registered; 1 exactly when phi[NUM_PHASES-1] is 1.

Behaviour:
- Reset (reset=0, immediate, asynchronous): phi=0, stalled=0, cycle_done=0, samp_bio=0, samp_int=0, all sync stages 0, state=PHASE, idx=0, ws_cnt=0, rec_cnt=0.
- First rising edge after reset release: phi=phi[0]. phi always reflects the state at the previous edge, i.e. one cycle of output latency.
- State PHASE with index idx (0-based):
  - If idx==WAIT_PHASE-1 and the stall condition holds, where stall = (bus_request && !bus_grant) || wait_states!=0: phi<=0, stalled<=1, ws_cnt<=wait_states, go to WAIT.
  - Otherwise: phi<=onehot(idx), stalled<=0, cycle_done<=(idx==NUM_PHASES-1), idx<=(idx+1) mod NUM_PHASES.
- State WAIT: phi stays 0, stalled=1.
  - If ws_cnt!=0: ws_cnt decrements by 1.
  - Else if (!bus_request || bus_grant): rec_cnt<=RECOVERY_CYCLES-1, go to REC.
  - Otherwise remain in WAIT.
  - Withdrawal of bus_request also releases the stall, which prevents deadlock.
- State REC:
  - If rec_cnt!=0: rec_cnt decrements by 1, phi=0, stalled=1.
  - Else: phi<=onehot(WAIT_PHASE-1), stalled<=0, idx<=WAIT_PHASE mod NUM_PHASES, go to PHASE.
- Stall length: phi-zero cycles = 1 + (wait_states+1) + (extra ungranted cycles) + RECOVERY_CYCLES - 1.
  - With wait_states=0 and immediate grant this is 2 cycles.
  - Exactly one phase bit is ever high, and no phase is ever skipped or repeated.
- bus_request/bus_grant and wait_states are ignored in every PHASE cycle other than WAIT_PHASE-1. Changes to wait_states during WAIT are ignored.
- Illegal or unreachable encodings (idx>=NUM_PHASES): next edge gives phi=0, idx=0, state=PHASE.
- Synchroniser: a SYNC_STAGES-deep shift of bio/int per bit, reset to 0; latency is SYNC_STAGES edges. It runs continuously, independent of stalls.
- Reset during WAIT or REC aborts the stall immediately. No stall state survives reset.

Test Plan:
1. Defaults, bus_request=0, wait_states=0, release reset -> phi cycles 000001, 000010, …, 100000 with period 6; cycle_done high on every 6th cycle; stalled never high.
2. Defaults, bus_request=1, bus_grant=0 from edge 1, grant raised before edge 8 -> phi=0 on edges 3–8 with stalled=1; edge 9 phi=000100; edge 10 phi=001000.
3. Defaults, wait_states=2, no request -> phi=0 on edges 3–6; phi=000100 at edge 7. Repeat with RECOVERY_CYCLES=3 -> phi=000100 at edge 9.
4. bus_request=1, grant=0 into WAIT, then drop bus_request with no grant -> REC on the next edge, then phi[2] on the following edge.
5. Assert reset mid-WAIT -> phi, stalled, samp_* go 0 without a clock edge; after release, first edge phi=000001.
6. NUM_PHASES=8, WAIT_PHASE=5, SYNC_STAGES=3: a one-cycle bio pulse appears on samp_bio 3 edges later for 1 cycle; a stall inserts before phi[4] and cycle_done aligns with phi[7].
